// File: rtl/acc_reg_bank_pkg.sv
// rtl/acc_reg_bank_pkg.sv - shared types and defaults for the accumulator register bank
package acc_reg_bank_pkg;

  localparam int ACC_W_DEF  = 8;
  localparam int ACC_PW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_reg_bank.sv
// rtl/acc_reg_bank.sv - accumulator/register file with swap and shadow-bank save/restore
// Entry 0 is the accumulator; the shadow bank is copied one entry per cycle under busy/done.
module acc_reg_bank
  import acc_reg_bank_pkg::*;
#(
  parameter int W  = ACC_W_DEF,
  parameter int PW = ACC_PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  dat_in,
  input  logic          imm_val,
  input  logic          acc_write,
  input  logic          reg_write,
  input  logic          swap,
  input  logic [PW:0]   addr,
  input  logic          save_req,
  input  logic          restore_req,
  output logic [W-1:0]  acc_out,
  output logic [W-1:0]  reg_out,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH = 2 ** PW;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  r_core   [DEPTH];
  logic [W-1:0]  r_shadow [DEPTH];
  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_next_cnt;
  logic [PW-1:0] w_idx;
  logic [W-1:0]  w_imm;

  assign w_idx = addr[PW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (save_req) begin
          w_next_state = SAVE;
          w_next_cnt   = '0;
        end else if (restore_req) begin
          w_next_state = RESTORE;
          w_next_cnt   = '0;
        end
      end
      SAVE, RESTORE: begin
        busy       = 1'b1;
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          done         = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Register writes only land in IDLE; while sequencing, the counter owns the bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_core[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (swap) begin
            r_core[0]     <= r_core[w_idx];
            r_core[w_idx] <= r_core[0];
          end else if (acc_write) begin
            r_core[0] <= dat_in;
          end else if (reg_write) begin
            r_core[w_idx] <= dat_in;
          end
        end
        SAVE:    r_shadow[r_cnt] <= r_core[r_cnt];
        RESTORE: r_core[r_cnt]   <= r_shadow[r_cnt];
        default: ;
      endcase
    end
  end

  always_comb begin
    w_imm        = '0;
    w_imm[PW:0]  = addr;
  end

  assign acc_out = r_core[0];
  assign reg_out = imm_val ? w_imm : r_core[w_idx];

endmodule

// File: tb/tb_acc_reg_bank.sv
// tb/tb_acc_reg_bank.sv - scoreboard bench for acc_reg_bank
module tb_acc_reg_bank;

  localparam int W     = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  dat_in;
  logic          imm_val;
  logic          acc_write;
  logic          reg_write;
  logic          swap;
  logic [PW:0]   addr;
  logic          save_req;
  logic          restore_req;
  logic [W-1:0]  acc_out;
  logic [W-1:0]  reg_out;
  logic          busy;
  logic          done;

  typedef struct {
    int           idx;
    logic [W-1:0] exp;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_core   [DEPTH];
  logic [W-1:0] m_shadow [DEPTH];
  int           n_pass  = 0;
  int           n_total = 0;

  acc_reg_bank #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .imm_val(imm_val),
    .acc_write(acc_write), .reg_write(reg_write), .swap(swap), .addr(addr),
    .save_req(save_req), .restore_req(restore_req), .acc_out(acc_out),
    .reg_out(reg_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_write   = 1'b0;
    reg_write   = 1'b0;
    swap        = 1'b0;
    save_req    = 1'b0;
    restore_req = 1'b0;
    imm_val     = 1'b0;
  endtask

  task automatic write_reg(input int a, input logic [W-1:0] d);
    reg_write = 1'b1;
    addr      = 5'(a);
    dat_in    = d;
    tick();
    reg_write = 1'b0;
    m_core[a] = d;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < DEPTH; i++) sb.push_back('{i, m_core[i]});
    imm_val = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      e    = sb.pop_front();
      addr = 5'(e.idx);
      #1;
      n_total++;
      if (reg_out !== e.exp)
        $display("FAIL %s core[%0d]: got %h expected %h", tag, e.idx, reg_out, e.exp);
      else n_pass++;
    end
    n_total++;
    if (acc_out !== m_core[0])
      $display("FAIL %s acc_out: got %h expected %h", tag, acc_out, m_core[0]);
    else n_pass++;
  endtask

  task automatic run_sequence(input string tag, input bit is_save, input bit poke);
    if (is_save) save_req = 1'b1; else restore_req = 1'b1;
    tick();
    save_req    = 1'b0;
    restore_req = 1'b0;
    for (int c = 1; c <= DEPTH; c++) begin
      n_total++;
      if (busy !== 1'b1 || done !== (c == DEPTH))
        $display("FAIL %s cycle %0d: busy=%b done=%b expected busy=1 done=%b",
                 tag, c, busy, done, (c == DEPTH));
      else n_pass++;
      if (poke && c == 3) begin
        reg_write = 1'b1;
        swap      = 1'b1;
        acc_write = 1'b1;
        addr      = 5'd4;
        dat_in    = 8'hEE;
      end
      tick();
      reg_write = 1'b0;
      swap      = 1'b0;
      acc_write = 1'b0;
    end
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s after: busy=%b done=%b expected 0 0", tag, busy, done);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      if (is_save) m_shadow[i] = m_core[i]; else m_core[i] = m_shadow[i];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    addr   = '0;
    dat_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_core[i]   = '0;
      m_shadow[i] = '0;
    end
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset busy/done: got %b%b expected 00", busy, done);
    else n_pass++;
    imm_val = 1'b1;
    addr    = 5'h13;
    #1;
    n_total++;
    if (reg_out !== 8'h13) $display("FAIL reset imm: got %h expected 13", reg_out);
    else n_pass++;
    check_bank("reset");
  endtask

  task automatic test_priority();
    acc_write = 1'b1;
    reg_write = 1'b1;
    addr      = 5'd2;
    dat_in    = 8'hA5;
    tick();
    acc_write = 1'b0;
    reg_write = 1'b0;
    m_core[0] = 8'hA5;
    check_bank("priority");
  endtask

  task automatic test_swap();
    write_reg(0, 8'h11);
    write_reg(7, 8'h77);
    swap = 1'b1;
    addr = 5'd7;
    tick();
    swap = 1'b0;
    m_core[0] = 8'h77;
    m_core[7] = 8'h11;
    n_total++;
    if (acc_out !== 8'h77 || reg_out !== 8'h11)
      $display("FAIL swap7: acc=%h reg=%h expected 77 11", acc_out, reg_out);
    else n_pass++;
    swap = 1'b1;
    addr = 5'd0;
    tick();
    swap = 1'b0;
    check_bank("swap0");
  endtask

  task automatic test_save_restore();
    for (int i = 0; i < DEPTH; i++) write_reg(i, 8'(i + 1));
    run_sequence("save", 1'b1, 1'b1);
    check_bank("save_core");
    for (int i = 0; i < DEPTH; i++) write_reg(i, 8'hFF);
    run_sequence("restore", 1'b0, 1'b1);
    check_bank("restore");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) write_reg(i, 8'h30 + 8'(i));
    save_req    = 1'b1;
    restore_req = 1'b1;
    tick();
    save_req    = 1'b0;
    restore_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_shadow[i] = m_core[i];
      tick();
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL both_req end: busy=%b expected 0", busy);
    else n_pass++;
    check_bank("both_req_core");
    for (int i = 0; i < DEPTH; i++) write_reg(i, 8'h00);
    run_sequence("b2b_restore", 1'b0, 1'b0);
    run_sequence("b2b_save", 1'b1, 1'b0);
    check_bank("both_req_shadow");
  endtask

  task automatic test_reset_mid_save();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_core[i]   = '0;
      m_shadow[i] = '0;
    end
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midreset: busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    check_bank("midreset");
    for (int i = 0; i < DEPTH; i++) write_reg(i, 8'h55);
    run_sequence("midreset_restore", 1'b0, 1'b0);
    check_bank("midreset_restore");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_swap();
    test_save_restore();
    test_back_to_back();
    test_reset_mid_save();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
